// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, NOP word
// and the default reset PC.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Branch targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface instruction_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: clear beats load, otherwise it holds.
module if_id_register
    import instruction_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instruction,
    output logic [31:0] PCReg,
    output logic        validD
);

    logic [31:0] instr_reg;
    logic [31:0] pc4_reg;
    logic        valid_reg;

    // clear inserts a bubble and leaves the PC+4 field as it was.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_reg <= NOP_INSTR;
            pc4_reg   <= 32'h0;
            valid_reg <= 1'b0;
        end else if (clear) begin
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
        end else if (load) begin
            instr_reg <= instr_in;
            pc4_reg   <= pc4_in;
            valid_reg <= 1'b1;
        end
    end

    assign instruction = instr_reg;
    assign PCReg       = pc4_reg;
    assign validD      = valid_reg;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, one-entry skid buffer for words acked during a stall,
// and the IDLE/REQ/HOLD request FSM feeding the IF/ID register.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hazardDetected,
    input  logic                       PCSrcD,
    input  logic [31:0]                PCbranchD,
    instruction_fetch_if.master        imem,
    output logic [31:0]                instruction,
    output logic [31:0]                PCReg,
    output logic                       validD
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  skid_instr_reg, skid_instr_next;
    logic [31:0]  skid_pc4_reg, skid_pc4_next;
    logic         skid_valid_reg, skid_valid_next;

    logic         ifid_load;
    logic         ifid_clear;
    logic [31:0]  ifid_instr;
    logic [31:0]  ifid_pc4;
    logic [31:0]  pc_plus4;

    assign pc_plus4  = pc_reg + PC_STEP;
    assign imem.req  = (state_reg == REQ);
    assign imem.addr = pc_reg;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc4_next   = skid_pc4_reg;
        skid_valid_next = skid_valid_reg;
        ifid_load       = 1'b0;
        ifid_clear      = 1'b0;
        ifid_instr      = imem.rdata;
        ifid_pc4        = pc_plus4;

        if (PCSrcD) begin
            // Redirect wins over stall and discards any ack in this cycle.
            pc_next         = word_align(PCbranchD);
            ifid_clear      = 1'b1;
            skid_valid_next = 1'b0;
            state_next      = REQ;
        end else begin
            unique case (state_reg)
                IDLE: state_next = REQ;
                REQ: begin
                    if (imem.ack && !hazardDetected) begin
                        ifid_load = 1'b1;
                        pc_next   = pc_plus4;
                    end else if (imem.ack) begin
                        skid_instr_next = imem.rdata;
                        skid_pc4_next   = pc_plus4;
                        skid_valid_next = 1'b1;
                        pc_next         = pc_plus4;
                        state_next      = HOLD;
                    end else if (!hazardDetected) begin
                        ifid_clear = 1'b1;
                    end
                end
                HOLD: begin
                    if (!hazardDetected) begin
                        ifid_load       = 1'b1;
                        ifid_instr      = skid_instr_reg;
                        ifid_pc4        = skid_pc4_reg;
                        skid_valid_next = 1'b0;
                        state_next      = REQ;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            skid_instr_reg <= NOP_INSTR;
            skid_pc4_reg   <= 32'h0;
            skid_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc4_reg   <= skid_pc4_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    if_id_register u_if_id (
        .clk         (clk),
        .reset       (reset),
        .load        (ifid_load),
        .clear       (ifid_clear),
        .instr_in    (ifid_instr),
        .pc4_in      (ifid_pc4),
        .instruction (instruction),
        .PCReg       (PCReg),
        .validD      (validD)
    );

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 hazardDetected  input  1  decode-stage stall; when 1, the IF/ID register SHALL hold.
REQ-005 PCSrcD  input  1  branch-taken redirect from decode.
REQ-006 PCbranchD  input  32  redirect target, valid when PCSrcD=1.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  fetch address; equals PC whenever imem_req=1.
REQ-009 imem_ack  input  1  imem_rdata valid for the imem_addr of the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instruction  output  32  IF/ID instruction register, driving the decode stage.
REQ-012 PCReg  output  32  IF/ID PC+4 of the held instruction.
REQ-013 validD  output  1  IF/ID holds a real instruction (0 = bubble/NOP).

Function
REQ-014 The FSM SHALL have states IDLE, REQ and HOLD; imem_req SHALL be 1 only in REQ.
REQ-015 IDLE SHALL go to REQ unconditionally on the next cycle.
REQ-016 In REQ, if imem_ack=1 and hazardDetected=0, the block SHALL load instruction<=imem_rdata, PCReg<=PC+4, validD<=1 and PC<=PC+4, and remain in REQ (one instruction per cycle).
REQ-017 In REQ, if imem_ack=1 and hazardDetected=1, the block SHALL store imem_rdata and PC+4 in a one-entry skid buffer, set PC<=PC+4, leave IF/ID unchanged and go to HOLD.
REQ-018 In REQ, if imem_ack=0 and hazardDetected=0, the block SHALL load a bubble (instruction<=32'h0, validD<=0, PCReg unchanged) and keep PC.
REQ-019 In REQ, if imem_ack=0 and hazardDetected=1, IF/ID and PC SHALL hold.
REQ-020 In HOLD, when hazardDetected=0, the skid contents SHALL move into IF/ID with validD<=1 and the FSM SHALL return to REQ; while hazardDetected=1, everything SHALL hold.
REQ-021 PCSrcD=1 SHALL take priority over every other event in every state: PC<={PCbranchD[31:2],2'b00}, instruction<=32'h0, validD<=0, skid emptied, next state REQ; a same-cycle imem_ack SHALL be discarded.
REQ-022 PCSrcD=1 together with hazardDetected=1 SHALL still redirect and flush (the flush overrides the stall).
REQ-023 PC arithmetic SHALL be 32-bit modulo 2^32: PC 32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-024 Fetch-to-decode latency SHALL be one cycle from the acked imem cycle to the instruction appearing at the output.
REQ-025 No instruction SHALL be lost or duplicated across any stall/ack/redirect sequence.

Reset
REQ-026 While reset=1 at a clock edge: PC<=RESET_PC, instruction<=32'h0, PCReg<=32'h0, validD<=0, skid emptied, state<=IDLE; reset SHALL override PCSrcD and hazardDetected.
REQ-027 imem_req SHALL be 0 during reset and in the first cycle after reset deasserts (IDLE).
REQ-028 A reset asserted mid-request SHALL drop the request; any ack in that cycle SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the NOP constant 32'h0 and the default RESET_PC.
REQ-030 The IF/ID register (instruction, PCReg, validD with hold/flush controls) SHALL be a sub-module named if_id_register; PC, skid buffer and FSM SHALL stay in instruction_fetch.

Verification
REQ-031 Reset with RESET_PC=0x100, then ack every cycle -> imem_addr 0x100, 0x104, 0x108; instruction follows one cycle later; PCReg 0x104, 0x108, 0x10C.
REQ-032 Ack at PC 0x200 while hazardDetected=1 for 3 cycles -> IF/ID unchanged, state HOLD, imem_req=0; one cycle after release, PCReg=0x204, validD=1; next imem_addr=0x204.
REQ-033 PCSrcD=1 with PCbranchD=0x403 and a same-cycle ack -> next imem_addr=0x400, validD=0, acked data never appears on instruction.
REQ-034 imem_ack held 0 for 4 cycles with no stall -> validD=0 and instruction=0 each cycle, imem_addr constant, no PC advance.
REQ-035 PC=0xFFFF_FFFC acked -> next imem_addr=0x0000_0000, PCReg=0x0000_0000.
REQ-036 reset pulsed in HOLD with skid full -> after reset, state IDLE, skid empty, first fetch at RESET_PC.
